// File: rtl/ysyx_25040111_idu.sv
// ----------------------------------------------------------------------------
// ysyx_25040111_idu -- decode/issue stage of the RV32E core.
//
// Holds one fetched instruction in a decode buffer, extracts its register
// fields, drives the register-file read ports, and checks a 16-entry busy
// scoreboard for RAW/WAW hazards. A hazard-free instruction moves, together
// with its operands, into a registered output stage under valid/ready.
//
// Ports
//   clock, resetn            core clock, asynchronous active-low reset
//   in_valid/in_ready        IFU handshake; in_inst/in_pc carry the word/PC
//   flush                    synchronous kill of everything the IDU holds
//   rf_ars1/rf_ars2/rf_ren   register-file read addresses and enables
//   rf_rs1/rf_rs2            read data (already forwards same-cycle writes)
//   wb_valid/wb_rd           writeback retiring a destination register
//   out_valid/out_ready      EXU handshake
//   out_pc/out_inst          issued PC and instruction word
//   out_rs1/out_rs2          issued operands (0 when a field is unused)
//   out_rd/out_rd_wen        destination and its write enable
//   out_illegal              undecodable word or non-RV32E register field
//   stall_cnt                count of hazard-stall cycles
// ----------------------------------------------------------------------------
module ysyx_25040111_idu (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic [3:0]  rf_ars1,
    output logic [3:0]  rf_ars2,
    output logic [1:0]  rf_ren,
    input  logic [31:0] rf_rs1,
    input  logic [31:0] rf_rs2,
    input  logic        wb_valid,
    input  logic [3:0]  wb_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_rs1,
    output logic [31:0] out_rs2,
    output logic [3:0]  out_rd,
    output logic        out_rd_wen,
    output logic        out_illegal,
    output logic [31:0] stall_cnt
);

    // Decode buffer
    logic        d_valid_q;
    logic [31:0] d_inst_q;
    logic [31:0] d_pc_q;

    // Output stage
    logic        out_valid_q;
    logic [31:0] out_pc_q;
    logic [31:0] out_inst_q;
    logic [31:0] out_rs1_q;
    logic [31:0] out_rs2_q;
    logic [3:0]  out_rd_q;
    logic        out_rd_wen_q;
    logic        out_illegal_q;

    // Scoreboard and counter
    logic [15:0] busy_q;
    logic [15:0] busy_d;
    logic [31:0] stall_cnt_q;

    // Decode results
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [3:0]  rs1_s;
    logic [3:0]  rs2_s;
    logic [3:0]  rd_s;
    logic        known_s;
    logic        use1_raw_s;
    logic        use2_raw_s;
    logic        wen_raw_s;
    logic        illegal_s;
    logic        use_rs1_s;
    logic        use_rs2_s;
    logic        rd_wen_s;
    logic        hazard_s;
    logic        issue_s;
    logic [15:0] wb_clr_mask_s;
    logic [15:0] fl_clr_mask_s;
    logic [15:0] set_mask_s;

    assign opcode_s = d_inst_q[6:0];
    assign funct3_s = d_inst_q[14:12];
    assign rs1_s    = d_inst_q[18:15];
    assign rs2_s    = d_inst_q[23:20];
    assign rd_s     = d_inst_q[10:7];

    // Opcode decode: which register fields the instruction reads and writes
    always_comb begin
        known_s    = 1'b1;
        use1_raw_s = 1'b0;
        use2_raw_s = 1'b0;
        wen_raw_s  = 1'b0;
        case (opcode_s)
            7'b0110011: begin
                use1_raw_s = 1'b1;
                use2_raw_s = 1'b1;
                wen_raw_s  = 1'b1;
            end
            7'b0100011, 7'b1100011: begin
                use1_raw_s = 1'b1;
                use2_raw_s = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                use1_raw_s = 1'b1;
                wen_raw_s  = 1'b1;
            end
            7'b0110111, 7'b0010111, 7'b1101111: begin
                wen_raw_s  = 1'b1;
            end
            7'b1110011: begin
                // CSR register forms read rs1; ecall/ebreak (funct3 0) touch nothing
                use1_raw_s = (funct3_s == 3'd1) || (funct3_s == 3'd2) || (funct3_s == 3'd3);
                wen_raw_s  = (funct3_s != 3'd0);
            end
            default: begin
                known_s    = 1'b0;
            end
        endcase
    end

    // A used field naming x16..x31 is not RV32E; illegal words read and write nothing
    assign illegal_s = !known_s
                     | (use1_raw_s & d_inst_q[19])
                     | (use2_raw_s & d_inst_q[24])
                     | (wen_raw_s  & d_inst_q[11]);
    assign use_rs1_s = use1_raw_s & !illegal_s;
    assign use_rs2_s = use2_raw_s & !illegal_s;
    assign rd_wen_s  = wen_raw_s & !illegal_s & (rd_s != 4'd0);

    // A writeback to the same register this cycle resolves the hazard (RF forwards)
    assign hazard_s = (use_rs1_s & busy_q[rs1_s] & !(wb_valid & (wb_rd == rs1_s)))
                    | (use_rs2_s & busy_q[rs2_s] & !(wb_valid & (wb_rd == rs2_s)))
                    | (rd_wen_s  & busy_q[rd_s]  & !(wb_valid & (wb_rd == rd_s)));

    assign issue_s  = d_valid_q & !hazard_s & !flush & (!out_valid_q | out_ready);
    assign in_ready = !flush & (!d_valid_q | issue_s);

    assign rf_ars1 = rs1_s;
    assign rf_ars2 = rs2_s;
    assign rf_ren  = {use_rs2_s & d_valid_q, use_rs1_s & d_valid_q};

    // Scoreboard next state: clears first, then the issue set, so set wins
    assign wb_clr_mask_s = wb_valid ? (16'd1 << wb_rd) : 16'd0;
    // An un-accepted output killed by flush will never retire its write
    assign fl_clr_mask_s = (flush & out_valid_q & out_rd_wen_q & !out_ready)
                           ? (16'd1 << out_rd_q) : 16'd0;
    assign set_mask_s    = (issue_s & rd_wen_s) ? (16'd1 << rd_s) : 16'd0;
    assign busy_d        = ((busy_q & ~wb_clr_mask_s & ~fl_clr_mask_s) | set_mask_s)
                           & 16'hFFFE;

    // Decode buffer: flush kills, handshake loads, issue empties
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            d_valid_q <= 1'b0;
            d_inst_q  <= 32'd0;
            d_pc_q    <= 32'd0;
        end else if (flush) begin
            d_valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            d_valid_q <= 1'b1;
            d_inst_q  <= in_inst;
            d_pc_q    <= in_pc;
        end else if (issue_s) begin
            d_valid_q <= 1'b0;
        end else begin
            d_valid_q <= d_valid_q;
        end
    end

    // Output stage: loads on issue, drops on accept, holds under backpressure
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= 32'd0;
            out_inst_q    <= 32'd0;
            out_rs1_q     <= 32'd0;
            out_rs2_q     <= 32'd0;
            out_rd_q      <= 4'd0;
            out_rd_wen_q  <= 1'b0;
            out_illegal_q <= 1'b0;
        end else if (flush) begin
            out_valid_q   <= 1'b0;
        end else if (issue_s) begin
            out_valid_q   <= 1'b1;
            out_pc_q      <= d_pc_q;
            out_inst_q    <= d_inst_q;
            out_rs1_q     <= use_rs1_s ? rf_rs1 : 32'd0;
            out_rs2_q     <= use_rs2_s ? rf_rs2 : 32'd0;
            out_rd_q      <= rd_s;
            out_rd_wen_q  <= rd_wen_s;
            out_illegal_q <= illegal_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_q   <= 1'b0;
        end else begin
            out_valid_q   <= out_valid_q;
        end
    end

    // Busy scoreboard register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy_q <= 16'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hazard-stall cycle counter, wraps naturally
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= 32'd0;
        end else if (d_valid_q && hazard_s && !flush) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_inst    = out_inst_q;
    assign out_rs1     = out_rs1_q;
    assign out_rs2     = out_rs2_q;
    assign out_rd      = out_rd_q;
    assign out_rd_wen  = out_rd_wen_q;
    assign out_illegal = out_illegal_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
